// File: rtl/riscv_csr_pkg.sv
// Shared definitions for the writeback trap sequencer: cause codes, CSR
// addresses, FSM state encoding and the internal trap-event payload.
package riscv_csr_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned CAUSE_W = 5;

   // Synchronous exception cause codes
   localparam logic [CAUSE_W-1:0] CAUSE_IAM  = 5'd0;
   localparam logic [CAUSE_W-1:0] CAUSE_II   = 5'd2;
   localparam logic [CAUSE_W-1:0] CAUSE_BK   = 5'd3;
   localparam logic [CAUSE_W-1:0] CAUSE_LAM  = 5'd4;
   localparam logic [CAUSE_W-1:0] CAUSE_ECFM = 5'd11;

   // Interrupt cause codes
   localparam logic [CAUSE_W-1:0] CAUSE_MSI  = 5'd3;
   localparam logic [CAUSE_W-1:0] CAUSE_MTI  = 5'd7;
   localparam logic [CAUSE_W-1:0] CAUSE_MEI  = 5'd11;

   // Machine-mode CSR addresses
   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } trap_state_e;

   typedef enum logic [1:0] {
      EV_NONE = 2'd0,
      EV_EXP  = 2'd1,
      EV_INT  = 2'd2,
      EV_MRET = 2'd3
   } trap_ev_e;

   typedef struct packed {
      trap_ev_e            ev;
      logic [CAUSE_W-1:0]  cause;
      logic [XLEN-1:0]     mtval;
      logic [XLEN-1:0]     pc;
   } trap_evt_t;

   // Highest-priority exception cause; only meaningful when a flag is set
   function automatic logic [CAUSE_W-1:0] exc_cause(input logic iam, input logic ii,
                                                    input logic bk, input logic lam);
      if (iam)      return CAUSE_IAM;
      else if (ii)  return CAUSE_II;
      else if (bk)  return CAUSE_BK;
      else if (lam) return CAUSE_LAM;
      else          return CAUSE_ECFM;
   endfunction

   // Highest-priority enabled interrupt; m = {meip, mtip, msip} already masked
   function automatic logic [CAUSE_W-1:0] irq_cause(input logic [2:0] m);
      if (m[2])      return CAUSE_MEI;
      else if (m[0]) return CAUSE_MSI;
      else           return CAUSE_MTI;
   endfunction

endpackage

// File: rtl/wb_trap_ctrl_if.sv
// WB/CSR-file bundle around the trap sequencer.
//   master: pipeline/CSR side, drives mem2wb_* and CSR state, reads trap outputs
//   slave : wb_trap_ctrl, reads mem2wb_* and CSR state, drives trap outputs
interface wb_trap_ctrl_if;
   import riscv_csr_pkg::*;

   // Retiring instruction
   logic                mem2wb_valid;
   logic [XLEN-1:0]     mem2wb_pc_ffout;
   logic [XLEN-1:0]     mem2wb_instr_ffout;
   logic                mem2wb_rv16;
   logic [XLEN-1:0]     mem2wb_badaddr;
   logic                mem2wb_e_iam;
   logic                mem2wb_e_ii;
   logic                mem2wb_e_bk;
   logic                mem2wb_e_lam;
   logic                mem2wb_e_ecfm;
   logic                mem2wb_mret;

   // Current CSR state
   logic                mstatus_mie;
   logic                mie_meie;
   logic                mie_mtie;
   logic                mie_msie;
   logic [XLEN-1:0]     mtvec;
   logic [XLEN-1:0]     mepc;

   // Trap outputs
   logic                wb2csrfile_exp;
   logic                wb2csrfile_int;
   logic                wb2csrfile_mret;
   logic [CAUSE_W-1:0]  wb2csrfile_causecode;
   logic [XLEN-1:0]     wb2csrfile_mtval;
   logic                wb2csrfile_rv16;
   logic [2:0]          irq_pending_sync;
   logic                flush;
   logic                redirect_valid;
   logic [XLEN-1:0]     redirect_pc;

   modport master (
      output mem2wb_valid, mem2wb_pc_ffout, mem2wb_instr_ffout, mem2wb_rv16,
             mem2wb_badaddr, mem2wb_e_iam, mem2wb_e_ii, mem2wb_e_bk,
             mem2wb_e_lam, mem2wb_e_ecfm, mem2wb_mret,
             mstatus_mie, mie_meie, mie_mtie, mie_msie, mtvec, mepc,
      input  wb2csrfile_exp, wb2csrfile_int, wb2csrfile_mret,
             wb2csrfile_causecode, wb2csrfile_mtval, wb2csrfile_rv16,
             irq_pending_sync, flush, redirect_valid, redirect_pc
   );

   modport slave (
      input  mem2wb_valid, mem2wb_pc_ffout, mem2wb_instr_ffout, mem2wb_rv16,
             mem2wb_badaddr, mem2wb_e_iam, mem2wb_e_ii, mem2wb_e_bk,
             mem2wb_e_lam, mem2wb_e_ecfm, mem2wb_mret,
             mstatus_mie, mie_meie, mie_mtie, mie_msie, mtvec, mepc,
      output wb2csrfile_exp, wb2csrfile_int, wb2csrfile_mret,
             wb2csrfile_causecode, wb2csrfile_mtval, wb2csrfile_rv16,
             irq_pending_sync, flush, redirect_valid, redirect_pc
   );

endinterface

// File: rtl/irq_sync.sv
// Multi-flop synchroniser for one raw interrupt line.
//   clk, rst_n : clock, async active-low clear
//   d_i        : raw asynchronous input
//   q_o        : synchronised output, SYNC_STAGES cycles behind d_i
module irq_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_STAGES-1:0] sync_q;

   // Shift chain; the last stage is the only one the core may look at
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
   end

   assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/wb_trap_ctrl.sv
// Writeback-stage trap sequencer feeding the CSR file.
//   clk, cpurst_n        : clock, async active-low reset
//   irq_meip/mtip/msip   : raw asynchronous interrupt lines
//   bus (slave)          : retiring instruction + CSR state in,
//                          CSR strobes / cause / mtval, flush and redirect out
module wb_trap_ctrl
   import riscv_csr_pkg::*;
#(
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned FLUSH_CYCLES = 3,
   parameter int unsigned VECTORED     = 1
) (
   input  logic          clk,
   input  logic          cpurst_n,
   input  logic          irq_meip,
   input  logic          irq_mtip,
   input  logic          irq_msip,
   wb_trap_ctrl_if.slave bus
);

   localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   logic [2:0]          irq_sync_c;      // {meip, mtip, msip}
   logic [2:0]          irq_mask_c;
   logic                irq_en_c;
   logic                exc_any_c;
   logic [XLEN-1:0]     base_c;
   trap_evt_t           evt_c;

   trap_state_e         state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                flush_q, flush_d;
   logic                exp_q, exp_d;
   logic                int_q, int_d;
   logic                mret_q, mret_d;
   logic                rvld_q, rvld_d;
   logic                rv16_q, rv16_d;
   logic [CAUSE_W-1:0]  cause_q, cause_d;
   logic [XLEN-1:0]     mtval_q, mtval_d;
   logic [XLEN-1:0]     rpc_q, rpc_d;

   // PC is captured into mepc by the CSR file itself; mtvec mode bits are ignored
   logic unused_c;
   assign unused_c = ^{bus.mem2wb_pc_ffout, bus.mtvec[1:0]};

   irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_meip (
      .clk(clk), .rst_n(cpurst_n), .d_i(irq_meip), .q_o(irq_sync_c[2]));
   irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mtip (
      .clk(clk), .rst_n(cpurst_n), .d_i(irq_mtip), .q_o(irq_sync_c[1]));
   irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_msip (
      .clk(clk), .rst_n(cpurst_n), .d_i(irq_msip), .q_o(irq_sync_c[0]));

   assign irq_mask_c = irq_sync_c & {bus.mie_meie, bus.mie_mtie, bus.mie_msie};
   assign irq_en_c   = bus.mstatus_mie & (|irq_mask_c);
   assign exc_any_c  = bus.mem2wb_e_iam | bus.mem2wb_e_ii | bus.mem2wb_e_bk |
                       bus.mem2wb_e_lam | bus.mem2wb_e_ecfm;
   assign base_c     = {bus.mtvec[XLEN-1:2], 2'b00};

   // Event arbitration for the retiring instruction: exception > interrupt > mret
   always_comb begin
      evt_c = '0;
      if (exc_any_c) begin
         evt_c.ev    = EV_EXP;
         evt_c.cause = exc_cause(bus.mem2wb_e_iam, bus.mem2wb_e_ii,
                                 bus.mem2wb_e_bk, bus.mem2wb_e_lam);
         evt_c.pc    = base_c;
         if (bus.mem2wb_e_iam)      evt_c.mtval = bus.mem2wb_badaddr;
         else if (bus.mem2wb_e_ii)  evt_c.mtval = bus.mem2wb_instr_ffout;
         else if (bus.mem2wb_e_bk)  evt_c.mtval = '0;
         else if (bus.mem2wb_e_lam) evt_c.mtval = bus.mem2wb_badaddr;
         else                       evt_c.mtval = '0;
      end else if (irq_en_c) begin
         evt_c.ev    = EV_INT;
         evt_c.cause = irq_cause(irq_mask_c);
         evt_c.pc    = (VECTORED != 0) ? base_c + (XLEN'(evt_c.cause) << 2) : base_c;
      end else if (bus.mem2wb_mret) begin
         evt_c.ev    = EV_MRET;
         evt_c.pc    = bus.mepc;
      end
   end

   // Next state / registered outputs
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      flush_d = flush_q;
      exp_d   = 1'b0;
      int_d   = 1'b0;
      mret_d  = 1'b0;
      rvld_d  = 1'b0;
      rv16_d  = rv16_q;
      cause_d = cause_q;
      mtval_d = mtval_q;
      rpc_d   = rpc_q;

      unique case (state_q)
         ST_IDLE: begin
            flush_d = 1'b0;
            if (bus.mem2wb_valid && (evt_c.ev != EV_NONE)) begin
               state_d = ST_FLUSH;
               cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
               flush_d = 1'b1;
               exp_d   = (evt_c.ev == EV_EXP);
               int_d   = (evt_c.ev == EV_INT);
               mret_d  = (evt_c.ev == EV_MRET);
               rvld_d  = 1'b1;
               rv16_d  = bus.mem2wb_rv16;
               cause_d = evt_c.cause;
               mtval_d = evt_c.mtval;
               rpc_d   = evt_c.pc;
            end
         end
         ST_FLUSH: begin
            // Counter holds the flush cycles still owed after the current one
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
               flush_d = 1'b0;
            end else begin
               cnt_d   = cnt_q - CNT_W'(1);
               flush_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge cpurst_n) begin
      if (!cpurst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         flush_q <= 1'b0;
         exp_q   <= 1'b0;
         int_q   <= 1'b0;
         mret_q  <= 1'b0;
         rvld_q  <= 1'b0;
         rv16_q  <= 1'b0;
         cause_q <= '0;
         mtval_q <= '0;
         rpc_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         flush_q <= flush_d;
         exp_q   <= exp_d;
         int_q   <= int_d;
         mret_q  <= mret_d;
         rvld_q  <= rvld_d;
         rv16_q  <= rv16_d;
         cause_q <= cause_d;
         mtval_q <= mtval_d;
         rpc_q   <= rpc_d;
      end
   end

   assign bus.wb2csrfile_exp       = exp_q;
   assign bus.wb2csrfile_int       = int_q;
   assign bus.wb2csrfile_mret      = mret_q;
   assign bus.wb2csrfile_causecode = cause_q;
   assign bus.wb2csrfile_mtval     = mtval_q;
   assign bus.wb2csrfile_rv16      = rv16_q;
   assign bus.irq_pending_sync     = irq_sync_c;
   assign bus.flush                = flush_q;
   assign bus.redirect_valid       = rvld_q;
   assign bus.redirect_pc          = rpc_q;

endmodule

// File: doc/wb_trap_ctrl.md
Name: wb_trap_ctrl

Overview:
Writeback-stage trap sequencer directly upstream of the CSR file. It picks between exception, interrupt and mret for the retiring instruction, then drives the wb2csrfile_* strobes, cause code and mtval into the CSR file. It also issues the pipeline flush and the redirect PC (mtvec base, vectored slot, or mepc). Raw interrupt lines are synchronised here; the rest of the core only sees qualified trap events.

Parameters:
SYNC_STAGES, 2, flop depth of the meip/mtip/msip synchronisers (min 2)
FLUSH_CYCLES, 3, cycles flush stays asserted after a trap/mret (min 1)
VECTORED, 1, 1: interrupts redirect to base+4*cause; 0: all traps go to base

Ports:
clk  in  1  core clock
cpurst_n  in  1  reset; asynchronous, active-low
mem2wb_valid  in  1  instruction in WB retires this cycle
mem2wb_pc_ffout  in  32  PC of the WB instruction
mem2wb_instr_ffout  in  32  WB instruction word
mem2wb_rv16  in  1  WB instruction is compressed
mem2wb_badaddr  in  32  faulting address (misaligned fetch/load)
mem2wb_e_iam / e_ii / e_bk / e_lam / e_ecfm  in  1 each  exception flags from WB instr
mem2wb_mret  in  1  WB instruction is mret
irq_meip / irq_mtip / irq_msip  in  1 each  raw asynchronous interrupt lines
mstatus_mie, mie_meie, mie_mtie, mie_msie  in  1 each  current CSR state
mtvec  in  32  trap vector; bits[1:0] ignored
mepc  in  32  return address
wb2csrfile_exp  out  1  exception taken (1-cycle pulse)
wb2csrfile_int  out  1  interrupt taken (1-cycle pulse)
wb2csrfile_mret  out  1  mret taken (1-cycle pulse)
wb2csrfile_causecode  out  5  cause code
wb2csrfile_mtval  out  32  trap value
wb2csrfile_rv16  out  1  registered copy of mem2wb_rv16 for the mepc+2/+4 choice
irq_pending_sync  out  3  synchronised {meip, mtip, msip}, for mip shadowing
flush  out  1  squash IF..MEM
redirect_valid  out  1  1-cycle pulse with redirect_pc
redirect_pc  out  32  new fetch PC

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, sync chains=0, flush counter=0, all outputs 0.
- Synchroniser: SYNC_STAGES flops per line; irq latency from raw line to visibility = SYNC_STAGES cycles.
- Interrupt eligibility: en = mstatus_mie & |(sync & {mie_meie,mie_mtie,mie_msie}).
- Interrupt priority: meip (11) > msip (3) > mtip (7).
- Exception priority/cause: iam 0 > ii 2 > bk 3 > lam 4 > ecfm 11.
- mtval rules: ii -> instr word; iam/lam -> badaddr; bk/ecfm -> 0. Interrupts write mtval=0; the CSR file ignores it.
- FSM states are IDLE and FLUSH.
- IDLE, evaluated only when mem2wb_valid=1, first match wins:
  1. any exception -> trap.
  2. else en -> interrupt trap.
  3. else mem2wb_mret -> mret.
  4. else nothing.
- Event output timing: strobe, cause, mtval, rv16, redirect_valid and redirect_pc are registered and appear one cycle after the decision cycle. flush asserts in that same cycle. Strobe and redirect are single-cycle pulses.
- Redirect PC:
  - exception -> {mtvec[31:2],2'b00}
  - interrupt -> base + (VECTORED ? cause<<2 : 0), 32-bit wrap
  - mret -> mepc
- After any event the FSM enters FLUSH; flush stays high FLUSH_CYCLES cycles, then the FSM returns to IDLE.
- In FLUSH, mem2wb_valid and all mem2wb_* inputs are ignored; squashed instructions never trap.
- Interrupts are level-sensitive and never latched. One still asserted after FLUSH is taken at the next retirement, and only if mstatus_mie is 1 by then.
- Exception plus eligible interrupt on the same retire: exception wins; the interrupt is re-evaluated after FLUSH.
- mret plus an exception flag: the exception wins.
- An interrupt arriving during FLUSH waits; no strobe is issued mid-flush.
- mem2wb_valid=0 in IDLE: no event, even with en=1. Interrupts are taken only at an instruction boundary.
- Reset asserted mid-FLUSH: outputs clear immediately; no pending redirect survives.
- At most one of exp/int/mret is high in any cycle.

Decomposition:
- Shared package (riscv_csr_pkg): cause-code constants, CSR address constants (0x300, 0x305, 0x341, 0x342, 0x343), FSM state encoding.
- One sub-module: irq_sync (parameterised SYNC_STAGES flop chain with async active-low clear), instantiated once per interrupt line.

Test Plan:
1. Reset then idle: cpurst_n low, raw irqs toggling -> all outputs 0; after release with no valid, no strobes.
2. Illegal instr: valid, e_ii=1, instr=0xFFFFFFFF, mtvec=0x8000_0101 -> next cycle exp=1, cause=2, mtval=0xFFFFFFFF, redirect_pc=0x8000_0100, flush high 3 cycles.
3. Timer interrupt vectored: mtvec=0x100, mstatus_mie=1, mie_mtie=1, irq_mtip raised -> after 2 cycles of sync plus a valid retire: int=1, cause=7, redirect_pc=0x11C, rv16 follows the WB instruction.
4. Simultaneous exception and meip: valid with e_lam, badaddr=0x1003, meip eligible -> exp=1, cause=4, mtval=0x1003. After FLUSH, the next valid retire gives int=1, cause=11.
5. mret: valid, mret=1, mepc=0x2000 -> mret=1, redirect_pc=0x2000. An irq asserted during FLUSH is taken only after FLUSH ends.
6. Async reset mid-FLUSH (cycle 2 of 3) -> flush and redirect drop immediately; after release the FSM is IDLE and no strobe is issued.
